reg_dump_ctrl: RTL

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/dbg_pkg.sv | 32 +++
 rtl/reg_dump_ctrl_if.sv | 10 +
 rtl/settle_counter.sv | 27 ++
 rtl/reg_dump_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared debug-sequencer types, instruction field map and read-instruction builder
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2,
        ST_FIN  = 2'd3
    } dump_state_t;

    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam int         REG_COUNT = 32;
    localparam logic [4:0] LAST_REG  = 5'(REG_COUNT - 1);

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;

    // rt = r0 and imm = 0, so the forced instruction only drives a read on port A
    function automatic logic [31:0] read_inst(input logic [5:0] opc, input logic [4:0] rs);
        logic [31:0] inst;
        inst                  = '0;
        inst[OPC_MSB:OPC_LSB] = opc;
        inst[RS_MSB:RS_LSB]   = rs;
        inst[RT_MSB:RT_LSB]   = 5'd0;
        return inst;
    endfunction

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// rtl/reg_dump_ctrl_if.sv - dump beat stream between the register dumper and its consumer
interface reg_dump_ctrl_if;
    logic        dump_valid;
    logic [4:0]  dump_reg;
    logic [31:0] dump_val;
    logic        dump_ready;

    modport master (output dump_valid, output dump_reg, output dump_val, input dump_ready);
    modport slave  (input dump_valid, input dump_reg, input dump_val, output dump_ready);
endinterface

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable settle down-counter with terminal-count flag at one
module settle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign tc = (cnt == WIDTH'(1));

endmodule

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - forces read instructions into the pipeline and streams all 32 GPRs out as beats
module reg_dump_ctrl
    import dbg_pkg::*;
#(
    parameter int         SETTLE   = 1,
    parameter logic [5:0] OPC_READ = OPC_ADDI
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            busA_probe,
    output logic                   override_inst,
    output logic [31:0]            force_inst,
    output logic                   busy,
    output logic                   done,
    reg_dump_ctrl_if.master        dump
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    dump_state_t state_q, state_d;
    logic [4:0]  idx_q;
    logic        accept, capture, handshake, abort_hit;
    logic        cnt_load, cnt_dec, cnt_tc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        abort_hit = abort && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_tc) begin
                    capture = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (dump.dump_ready) begin
                    handshake = 1'b1;
                    if (idx_q == LAST_REG) begin
                        state_d = ST_FIN;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // abort overrides whatever the current state wanted, including a same-cycle handshake
        if (abort_hit) begin
            state_d   = ST_IDLE;
            capture   = 1'b0;
            handshake = 1'b0;
            cnt_load  = 1'b0;
            cnt_dec   = 1'b0;
        end
    end

    settle_counter #(.WIDTH(4)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (SETTLE_CNT),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q           <= '0;
            dump.dump_valid <= 1'b0;
            dump.dump_reg   <= '0;
            dump.dump_val   <= '0;
            done            <= 1'b0;
        end else begin
            done <= (state_q == ST_FIN) && !abort_hit;
            if (abort_hit) begin
                dump.dump_valid <= 1'b0;
            end else if (accept) begin
                idx_q <= '0;
            end else if (capture) begin
                dump.dump_valid <= 1'b1;
                dump.dump_reg   <= idx_q;
                dump.dump_val   <= busA_probe;
            end else if (handshake) begin
                dump.dump_valid <= 1'b0;
                if (idx_q != LAST_REG) begin
                    idx_q <= idx_q + 5'd1;
                end
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign override_inst = (state_q == ST_WAIT) || (state_q == ST_OUT);
    assign force_inst    = override_inst ? read_inst(OPC_READ, idx_q) : 32'd0;

endmodule
